// File: rtl/iterative_divider_if.sv
// rtl/iterative_divider_if.sv - request/response bundle between the execute stage and the divider
interface iterative_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - restoring shift-subtract DIV/DIVU/REM/REMU unit, one quotient bit per cycle
module iterative_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    iterative_divider_if.slave div
);

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] result_q;
    logic [1:0]       op_q;
    logic             q_neg;
    logic             r_neg;
    logic             special_q;
    logic             div_zero_q;

    logic             accept;
    logic             load_result;

    // Request decode, evaluated on the raw operands in the accepting cycle
    logic             is_signed;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic             div_zero_in;
    logic             ovf_in;
    logic             special_in;

    always_comb begin
        is_signed   = ~div.op[0];
        dvd_neg     = is_signed & div.dividend[WIDTH-1];
        dvs_neg     = is_signed & div.divisor[WIDTH-1];
        dvd_abs     = dvd_neg ? (~div.dividend + 1'b1) : div.dividend;
        dvs_abs     = dvs_neg ? (~div.divisor + 1'b1) : div.divisor;
        div_zero_in = (div.divisor == '0);
        ovf_in      = is_signed && (div.dividend == MIN_VAL) && (div.divisor == '1);
        special_in  = div_zero_in | ovf_in;
    end

    // The partial remainder keeps one extra bit so divisors with the MSB set never overflow
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_sub;
    logic             take;

    always_comb begin
        r_shift = {rem_q, quo_q[WIDTH-1]};
        take    = (r_shift >= {1'b0, dvs_q});
        r_sub   = r_shift[WIDTH-1:0] - dvs_q;
    end

    logic [WIDTH-1:0] mag;
    logic             mag_neg;
    logic [WIDTH-1:0] fix_val;

    always_comb begin
        mag     = op_q[1] ? rem_q : quo_q;
        mag_neg = op_q[1] ? r_neg : q_neg;
        fix_val = mag_neg ? (~mag + 1'b1) : mag;
        if (special_q) begin
            if (div_zero_q) begin
                fix_val = op_q[1] ? quo_q : '1;
            end else begin
                fix_val = op_q[1] ? '0 : MIN_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        load_result = 1'b0;
        div.busy    = 1'b0;
        div.done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (div.start && !div.flush) begin
                    accept    = 1'b1;
                    state_nxt = special_in ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                div.busy = 1'b1;
                if (div.flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                div.busy = 1'b1;
                if (div.flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    load_result = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                div.done = 1'b1;
                if (div.start && !div.flush) begin
                    accept    = 1'b1;
                    state_nxt = special_in ? S_FIX : S_CALC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // On the special path quo_q holds the raw dividend, which REM by zero returns unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            op_q       <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            special_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                cnt        <= '0;
                quo_q      <= special_in ? div.dividend : dvd_abs;
                rem_q      <= '0;
                dvs_q      <= dvs_abs;
                op_q       <= div.op;
                q_neg      <= dvd_neg ^ dvs_neg;
                r_neg      <= dvd_neg;
                special_q  <= special_in;
                div_zero_q <= div_zero_in;
            end else if (state == S_CALC) begin
                cnt   <= cnt + CNT_W'(1);
                quo_q <= {quo_q[WIDTH-2:0], take};
                rem_q <= take ? r_sub : r_shift[WIDTH-1:0];
            end
            if (load_result) begin
                result_q <= fix_val;
            end
        end
    end

    assign div.result = result_q;

endmodule
